acc_mem_responder: RTL and testbench
====================================

// Module: acc_mem_responder
// PURPOSE
//  Memory-side responder for the edge-detection accelerator bus (addr/dataR/dataW/en/we).
//  Holds the source image (words 0..25343) and the result image (words 25344..50687).
//  Sits between the accelerator under test and the testbench. Serves accelerator reads
//  and writes with a fixed read latency. A secondary host port lets the bench preload
//  and dump images without reaching into the array.
// PARAMETERS
//  ADDR_W    16     word address width (halfword_t)
//  DATA_W    32     data width (word_t, 4 pixels, byte 0 = lowest address pixel)
//  DEPTH     50688  implemented words (2 x 352x288/4)
//  READ_LAT  1      cycles from read request edge to dataR valid; legal 1..4
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high
//  addr         in   ADDR_W  accelerator word address
//  dataW        in   DATA_W  accelerator write data
//  dataR        out  DATA_W  accelerator read data
//  en           in   1       accelerator request
//  we           in   1       1 = write, 0 = read (qualified by en)
//  host_req     in   1       host access request
//  host_we      in   1       host write/read select
//  host_addr    in   ADDR_W  host word address
//  host_wdata   in   DATA_W  host write data
//  host_gnt     out  1       host access accepted this cycle (combinational)
//  host_rdata   out  DATA_W  host read data
//  host_rvalid  out  1       host_rdata valid, 1-cycle pulse
//  addr_err     out  1       sticky out-of-range flag
//  err_addr     out  ADDR_W  first offending address
// BEHAVIOUR
//  Reset values:
//   - dataR, host_rdata, err_addr = 0.
//   - host_rvalid, addr_err = 0.
//   - Read pipeline flushed. Array contents are NOT reset.
//  Accelerator read (en=1, we=0 at edge N):
//   - dataR = mem[addr] from edge N+READ_LAT.
//   - dataR holds that value until the next read completes. Never returns X.
//  Accelerator write (en=1, we=1 at edge N):
//   - mem[addr] <= dataW at edge N. dataR is unchanged.
//   - A read issued at edge N+1 to the same address returns the new data.
//  Back-to-back requests:
//   - One new request accepted per cycle.
//   - Reads pipelined: READ_LAT reads may be in flight. Completion order = issue order.
//  Arbitration:
//   - Accelerator has absolute priority. host_gnt = host_req & ~en.
//   - An ungranted host request must be held by the bench. No queueing.
//  Host read granted at edge N:
//   - host_rdata = mem[host_addr] at edge N+1, host_rvalid pulse at edge N+1.
//   - Fixed 1-cycle latency, independent of READ_LAT.
//  Host write granted at edge N: mem written at edge N.
//  Out-of-range access (addr >= DEPTH, either port):
//   - Write ignored. Read returns 0 at normal latency.
//   - addr_err set. err_addr captured only on the first error.
//   - Both clear only on reset.
//  en=0 or we=X/Z with en=0: no effect, no error check.
//  Reset mid-operation: in-flight reads discarded; no completion after reset deasserts.
//  Address arithmetic is unsigned ADDR_W. No wrap; >= DEPTH is an error, never aliased.
// CONFIGURATION
//  ACC_MEM_STATS_EN defined:
//   - Adds outputs rd_count[31:0], wr_count[31:0], reset to 0.
//   - Count accepted accelerator reads/writes, including out-of-range ones. Saturate at 2^32-1.
//   - Host accesses are not counted.
//  ACC_MEM_STATS_EN undefined: ports and counters absent; all else identical.
// STRUCTURE
//  Package acc_mem_pkg:
//   - addr_t, word_t typedefs.
//   - IMG_WORDS=25344, DST_OFFSET=25344, MEM_DEPTH=50688.
//  Sub-module acc_mem_rd_pipe:
//   - Parameterised READ_LAT-deep shift register of {valid, data}, async reset clears valid.
//   - Output register holds the last valid data.
//  Top holds the array, arbitration, error capture and optional stats.
// TESTING
//  1. Host write mem[5]=32'hA1B2C3D4; acc read addr=5 -> dataR=32'hA1B2C3D4 one cycle after the read edge (READ_LAT=1).
//  2. READ_LAT=3: reads of addr 0,1,2 on consecutive edges -> values appear in order 3 edges after each request; dataR holds addr 2 data afterwards.
//  3. Acc write addr=25344 data=32'h00FF00FF, acc read same addr next cycle -> 32'h00FF00FF.
//  4. host_req with en=1 -> host_gnt=0 and memory unchanged; en drops -> host_gnt=1 and host_rvalid pulses next cycle.
//  5. Acc read addr=50688, then write addr=60000 -> dataR=0, addr_err=1, err_addr=50688 (not 60000), no array change.
//  6. Assert reset while a READ_LAT=2 read is in flight -> dataR=0, no late completion; with ACC_MEM_STATS_EN, 3 reads + 2 writes -> rd_count=3, wr_count=2.

Source files
------------

// File: rtl/acc_mem_pkg.sv
// Shared types and constants for the accelerator memory responder.
// Image geometry: source at words 0.., result at DST_OFFSET...
package acc_mem_pkg;

  localparam int IMG_WORDS  = 25344;
  localparam int DST_OFFSET = 25344;
  localparam int MEM_DEPTH  = 50688;

  typedef logic [15:0] addr_t;
  typedef logic [31:0] word_t;

  function automatic logic in_range(
    input logic [31:0] a,
    input int unsigned depth
  );
    return a < depth;
  endfunction

endpackage

// File: rtl/acc_mem_rd_pipe.sv
// READ_LAT-deep {valid,data} read pipeline with a held output register.
// Ports: clk, reset, v_i/d_i (request + data), q_o (last completed read).
module acc_mem_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              v_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [LAT-1:0]    v_q;
  logic [DATA_W-1:0] d_q [LAT];
  logic [DATA_W-1:0] out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= '0;
      out_q <= '0;
      for (int i = 0; i < LAT; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= v_i;
      d_q[0] <= d_i;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
      if (v_q[LAT-1]) out_q <= d_q[LAT-1];
    end
  end

  assign q_o = out_q;

endmodule

// File: rtl/acc_mem_responder.sv
// Memory responder: accelerator port (priority) + host preload/dump port.
// Ports: clk, reset, addr/dataW/dataR/en/we, host_*, addr_err/err_addr;
// optional rd_count/wr_count when ACC_MEM_STATS_EN is defined.
module acc_mem_responder
  import acc_mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = MEM_DEPTH,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataW,
  output logic [DATA_W-1:0] dataR,
  input  logic              en,
  input  logic              we,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              addr_err,
  output logic [ADDR_W-1:0] err_addr
`ifdef ACC_MEM_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc_rd, acc_wr;
  logic              acc_ok, host_ok;
  logic [IW-1:0]     acc_idx, host_idx;
  logic [DATA_W-1:0] rd_d;

  logic              hrd_pend_q, hrd_ok_q;
  logic [IW-1:0]     hrd_idx_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              host_rvalid_q;

  logic              err_hit;
  logic [ADDR_W-1:0] err_val;
  logic              addr_err_q;
  logic [ADDR_W-1:0] err_addr_q;

  assign acc_rd   = en & ~we;
  assign acc_wr   = en & we;
  assign acc_ok   = in_range(32'(addr), DEPTH);
  assign host_ok  = in_range(32'(host_addr), DEPTH);
  assign acc_idx  = addr[IW-1:0];
  assign host_idx = host_addr[IW-1:0];
  assign host_gnt = host_req & ~en;

  // Single write port: accelerator wins, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (acc_wr & acc_ok)
      mem_q[acc_idx] <= dataW;
    else if (host_gnt & host_we & host_ok)
      mem_q[host_idx] <= host_wdata;
  end

  assign rd_d = acc_ok ? mem_q[acc_idx] : '0;

  acc_mem_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (READ_LAT)
  ) u_rd_pipe (
    .clk   (clk),
    .reset (reset),
    .v_i   (acc_rd),
    .d_i   (rd_d),
    .q_o   (dataR)
  );

  // Host read: address latched at grant, data registered one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hrd_pend_q    <= 1'b0;
      hrd_ok_q      <= 1'b0;
      hrd_idx_q     <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      hrd_pend_q    <= host_gnt & ~host_we;
      hrd_ok_q      <= host_ok;
      hrd_idx_q     <= host_idx;
      host_rvalid_q <= hrd_pend_q;
      if (hrd_pend_q)
        host_rdata_q <= hrd_ok_q ? mem_q[hrd_idx_q] : '0;
    end
  end

  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;

  assign err_hit = (en & ~acc_ok) | (host_gnt & ~host_ok);
  assign err_val = en ? addr : host_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err_q <= 1'b0;
      err_addr_q <= '0;
    end else if (err_hit & ~addr_err_q) begin
      addr_err_q <= 1'b1;
      err_addr_q <= err_val;
    end
  end

  assign addr_err = addr_err_q;
  assign err_addr = err_addr_q;

`ifdef ACC_MEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (acc_rd && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (acc_wr && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_acc_mem_responder.sv
// Directed bench: three responders (READ_LAT 1/2/3) share one stimulus.
// Each step checks outputs #1 after the rising edge.
module tb_acc_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [31:0] dataW;
  logic        en, we;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;

  logic [31:0] dataR1, dataR2, dataR3;
  logic        gnt1, gnt2, gnt3;
  logic [31:0] hrd1, hrd2, hrd3;
  logic        hrv1, hrv2, hrv3;
  logic        aerr1, aerr2, aerr3;
  logic [15:0] eaddr1, eaddr2, eaddr3;
`ifdef ACC_MEM_STATS_EN
  logic [31:0] rdc1, wrc1, rdc2, wrc2, rdc3, wrc3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  acc_mem_responder #(.READ_LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .addr(addr), .dataW(dataW),
    .dataR(dataR1), .en(en), .we(we),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(gnt1), .host_rdata(hrd1), .host_rvalid(hrv1),
    .addr_err(aerr1), .err_addr(eaddr1)
`ifdef ACC_MEM_STATS_EN
    , .rd_count(rdc1), .wr_count(wrc1)
`endif
  );

  acc_mem_responder #(.READ_LAT(2)) u_l2 (
    .clk(clk), .reset(reset), .addr(addr), .dataW(dataW),
    .dataR(dataR2), .en(en), .we(we),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(gnt2), .host_rdata(hrd2), .host_rvalid(hrv2),
    .addr_err(aerr2), .err_addr(eaddr2)
`ifdef ACC_MEM_STATS_EN
    , .rd_count(rdc2), .wr_count(wrc2)
`endif
  );

  acc_mem_responder #(.READ_LAT(3)) u_l3 (
    .clk(clk), .reset(reset), .addr(addr), .dataW(dataW),
    .dataR(dataR3), .en(en), .we(we),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(gnt3), .host_rdata(hrd3), .host_rvalid(hrv3),
    .addr_err(aerr3), .err_addr(eaddr3)
`ifdef ACC_MEM_STATS_EN
    , .rd_count(rdc3), .wr_count(wrc3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_req   = 1'b0;
  endtask

  task automatic acc_rd(input logic [15:0] a);
    en   = 1'b1;
    we   = 1'b0;
    addr = a;
    tick();
    en   = 1'b0;
  endtask

  task automatic acc_wr(input logic [15:0] a, input logic [31:0] d);
    en    = 1'b1;
    we    = 1'b1;
    addr  = a;
    dataW = d;
    tick();
    en    = 1'b0;
    we    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    addr = '0; dataW = '0; en = 1'b0; we = 1'b0;
    host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;
    tick();
    tick();
    chk("rst_dataR1", dataR1, 32'h0);
    chk("rst_dataR3", dataR3, 32'h0);
    chk("rst_hrdata", hrd1, 32'h0);
    chk("rst_hrvalid", 32'(hrv1), 32'h0);
    chk("rst_addr_err", 32'(aerr1), 32'h0);
    chk("rst_err_addr", 32'(eaddr1), 32'h0);
    reset = 1'b0;
    tick();

    // 1: host write, accelerator read back
    host_req = 1'b1; host_we = 1'b1;
    host_addr = 16'd5; host_wdata = 32'hA1B2C3D4;
    #1;
    chk("t1_gnt", 32'(gnt1), 32'h1);
    tick();
    host_req = 1'b0;
    host_wr(16'd0, 32'h10101010);
    host_wr(16'd1, 32'h20202020);
    host_wr(16'd2, 32'h30303030);
    host_wr(16'd3, 32'h33333333);
    host_wr(16'd7, 32'h11111111);
    host_wr(16'd9312, 32'h12345678);
    acc_rd(16'd5);
    chk("t1_l1_early", dataR1, 32'h0);
    tick();
    chk("t1_l1", dataR1, 32'hA1B2C3D4);
    chk("t1_l2_early", dataR2, 32'h0);
    tick();
    chk("t1_l2", dataR2, 32'hA1B2C3D4);
    chk("t1_l3_early", dataR3, 32'h0);
    tick();
    chk("t1_l3", dataR3, 32'hA1B2C3D4);

    // 2: pipelined reads 0,1,2 on consecutive edges
    en = 1'b1; we = 1'b0; addr = 16'd0;
    tick();
    addr = 16'd1;
    tick();
    chk("t2_l1_r0", dataR1, 32'h10101010);
    addr = 16'd2;
    tick();
    en = 1'b0;
    chk("t2_l1_r1", dataR1, 32'h20202020);
    chk("t2_l2_r0", dataR2, 32'h10101010);
    chk("t2_l3_old", dataR3, 32'hA1B2C3D4);
    tick();
    chk("t2_l1_r2", dataR1, 32'h30303030);
    chk("t2_l2_r1", dataR2, 32'h20202020);
    chk("t2_l3_r0", dataR3, 32'h10101010);
    tick();
    chk("t2_l2_r2", dataR2, 32'h30303030);
    chk("t2_l3_r1", dataR3, 32'h20202020);
    tick();
    chk("t2_l3_r2", dataR3, 32'h30303030);
    tick();
    chk("t2_l3_hold", dataR3, 32'h30303030);

    // 3: write result region, read it on the next edge
    acc_wr(16'd25344, 32'h00FF00FF);
    chk("t3_wr_keeps", dataR1, 32'h30303030);
    acc_rd(16'd25344);
    tick();
    chk("t3_rd", dataR1, 32'h00FF00FF);

    // 4: host blocked by accelerator, then granted
    en = 1'b1; we = 1'b0; addr = 16'd5;
    host_req = 1'b1; host_we = 1'b1;
    host_addr = 16'd7; host_wdata = 32'hDEADBEEF;
    #1;
    chk("t4_nogrant", 32'(gnt1), 32'h0);
    tick();
    en = 1'b0;
    host_we = 1'b0;
    #1;
    chk("t4_grant", 32'(gnt1), 32'h1);
    tick();
    host_req = 1'b0;
    chk("t4_acc_rd", dataR1, 32'hA1B2C3D4);
    chk("t4_rv_early", 32'(hrv1), 32'h0);
    tick();
    chk("t4_rvalid", 32'(hrv1), 32'h1);
    chk("t4_rdata", hrd1, 32'h11111111);
    tick();
    chk("t4_rv_pulse", 32'(hrv1), 32'h0);

    // 5: out-of-range read then write
    acc_rd(16'd50688);
    tick();
    chk("t5_dataR0", dataR1, 32'h0);
    chk("t5_err", 32'(aerr1), 32'h1);
    chk("t5_eaddr", 32'(eaddr1), 32'd50688);
    acc_wr(16'd60000, 32'hCAFEBABE);
    chk("t5_eaddr_kept", 32'(eaddr1), 32'd50688);
    chk("t5_err_kept", 32'(aerr2), 32'h1);
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd9312;
    tick();
    host_req = 1'b0;
    tick();
    chk("t5_noalias", hrd1, 32'h12345678);

    // 6: reset with a READ_LAT=2 read in flight
    acc_rd(16'd3);
    reset = 1'b1;
    #1;
    chk("t6_l2_rst", dataR2, 32'h0);
    chk("t6_l1_rst", dataR1, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("t6_l2_nolate", dataR2, 32'h0);
    chk("t6_l3_nolate", dataR3, 32'h0);
    chk("t6_err_clr", 32'(aerr1), 32'h0);
    chk("t6_eaddr_clr", 32'(eaddr1), 32'h0);
    acc_rd(16'd5);
    tick();
    chk("t6_mem_kept", dataR1, 32'hA1B2C3D4);
`ifdef ACC_MEM_STATS_EN
    acc_rd(16'd1);
    acc_rd(16'd50688);
    acc_wr(16'd4, 32'h44444444);
    acc_wr(16'd60000, 32'h55555555);
    host_wr(16'd6, 32'h66666666);
    chk("t6_rd_count", rdc1, 32'd3);
    chk("t6_wr_count", wrc1, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
